// File: rtl/pwm_pkg.sv
// Shared constants for the multi-channel PWM generator: output mode encodings
// and the servo window divider.
package pwm_pkg;

    localparam logic MODE_NORMAL = 1'b0;
    localparam logic MODE_SERVO  = 1'b1;
    localparam int   SERVO_DIV   = 20;

endpackage

// File: rtl/pwm_timebase.sv
// Shared time base: programmable prescaler feeding a free-running period
// counter, plus the tick/wrap strobes and the registered period-start pulse.
module pwm_timebase #(
    parameter int PSC_W = 32,
    parameter int RES   = 8
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [PSC_W-1:0] psc_i,
    output logic             tick,
    output logic             wrap,
    output logic [RES-1:0]   cnt,
    output logic             period_o
);

    logic [PSC_W-1:0] q_q, q_d;
    logic [RES-1:0]   cnt_q, cnt_d;
    logic             period_q, period_d;

    // Disabled means parked at zero so the first enabled period is a full one.
    always_comb begin
        tick     = en_i && (q_q == psc_i);
        wrap     = tick && (cnt_q == {RES{1'b1}});
        q_d      = q_q + 1'b1;
        cnt_d    = cnt_q;
        period_d = wrap;
        if (!en_i) begin
            q_d      = '0;
            cnt_d    = '0;
            period_d = 1'b0;
        end else if (tick) begin
            q_d   = '0;
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            q_q      <= '0;
            cnt_q    <= '0;
            period_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

    assign cnt      = cnt_q;
    assign period_o = period_q;

endmodule

// File: rtl/pwm_multich.sv
// Multi-channel PWM with shadowed duty registers committed at period wrap.
// Define PWM_SERVO_EN to add the 5-10 % servo pulse mapping selected by mode_i.
module pwm_multich
    import pwm_pkg::*;
#(
    parameter  int CH    = 3,
    parameter  int RES   = 8,
    parameter  int PSC_W = 32,
    localparam int CHW   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [PSC_W-1:0] psc_i,
    input  logic             wr_valid_i,
    input  logic [CHW-1:0]   wr_ch_i,
    input  logic [RES:0]     wr_duty_i,
    output logic             wr_ready_o,
    input  logic             mode_i,
    output logic [CH-1:0]    pwm_o,
    output logic             period_o
);

    localparam logic [RES:0] FULL = {1'b1, {RES{1'b0}}};

    logic               unusedTick;
    logic               wrap;
    logic [RES-1:0]     cnt;
    logic               commit;
    logic               accept;
    logic [RES:0]       dutyClamped;
    logic [CH-1:0]      pendFlag;
    logic [(1<<CHW)-1:0] pendPad;

    pwm_timebase #(
        .PSC_W(PSC_W),
        .RES  (RES)
    ) u_timebase (
        .clk     (clk),
        .rst_i   (rst_i),
        .en_i    (en_i),
        .psc_i   (psc_i),
        .tick    (unusedTick),
        .wrap    (wrap),
        .cnt     (cnt),
        .period_o(period_o)
    );

    assign commit = wrap || !en_i;

    // Unused channel codes read a zero pad bit, so they always look ready.
    always_comb begin
        pendPad          = '0;
        pendPad[CH-1:0]  = pendFlag;
        dutyClamped      = (wr_duty_i > FULL) ? FULL : wr_duty_i;
    end

    assign wr_ready_o = !pendPad[wr_ch_i];
    assign accept     = wr_valid_i && wr_ready_o;

`ifdef PWM_SERVO_EN
    localparam int             SB      = (1 << RES) / SERVO_DIV;
    localparam logic [2*RES:0] SB_WIDE = (2*RES+1)'(SB);
    localparam logic [RES:0]   SB_THR  = (RES+1)'(SB);

    logic mode_q, mode_d;

    // Thresholds computed at a commit use the mode sampled in that same cycle.
    assign mode_d = commit ? mode_i : mode_q;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            mode_q <= MODE_NORMAL;
        end else begin
            mode_q <= mode_d;
        end
    end
`else
    logic unusedMode;
    assign unusedMode = mode_i;
`endif

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [RES:0] pendDuty_q, pendDuty_d;
        logic [RES:0] actThr_q, actThr_d;
        logic [RES:0] thr;
        logic         pendFlag_q, pendFlag_d;
        logic         pwm_q, pwm_d;
        logic         hit;
`ifdef PWM_SERVO_EN
        logic [2*RES:0] prod;
`endif

        // Ready is low while pending, so a write and a commit never collide.
        always_comb begin
            hit = accept && (wr_ch_i == CHW'(c));
`ifdef PWM_SERVO_EN
            prod = {{RES{1'b0}}, pendDuty_q} * SB_WIDE;
            thr  = (mode_d == MODE_SERVO) ? (SB_THR + (RES+1)'(prod >> RES)) : pendDuty_q;
`else
            thr  = pendDuty_q;
`endif
            pendDuty_d = pendDuty_q;
            pendFlag_d = pendFlag_q;
            actThr_d   = actThr_q;
            if (commit && pendFlag_q) begin
                actThr_d   = thr;
                pendFlag_d = 1'b0;
            end
            if (hit) begin
                pendDuty_d = dutyClamped;
                pendFlag_d = 1'b1;
            end
            pwm_d = en_i && ({1'b0, cnt} < actThr_q);
        end

        always_ff @(posedge clk) begin
            if (rst_i) begin
                pendDuty_q <= '0;
                pendFlag_q <= 1'b0;
                actThr_q   <= '0;
                pwm_q      <= 1'b0;
            end else begin
                pendDuty_q <= pendDuty_d;
                pendFlag_q <= pendFlag_d;
                actThr_q   <= actThr_d;
                pwm_q      <= pwm_d;
            end
        end

        assign pendFlag[c] = pendFlag_q;
        assign pwm_o[c]    = pwm_q;
    end

endmodule

// File: tb/tb_pwm_multich.sv
// Directed bench for pwm_multich (CH=3, RES=8); the servo scenario is built
// when PWM_SERVO_EN is defined, otherwise mode_i is shown to be ignored.
module tb_pwm_multich;

    localparam int CH    = 3;
    localparam int RES   = 8;
    localparam int PSC_W = 32;
    localparam int LIMIT = 5000;

    logic             clk;
    logic             rst;
    logic             en;
    logic [PSC_W-1:0] psc;
    logic             wrValid;
    logic [1:0]       wrCh;
    logic [RES:0]     wrDuty;
    logic             wrReady;
    logic             mode;
    logic [CH-1:0]    pwm;
    logic             periodPulse;

    int errors;
    int checks;
    int highCnt[CH];
    int periodLen;
    bit timedOut;

    pwm_multich #(
        .CH   (CH),
        .RES  (RES),
        .PSC_W(PSC_W)
    ) dut (
        .clk       (clk),
        .rst_i     (rst),
        .en_i      (en),
        .psc_i     (psc),
        .wr_valid_i(wrValid),
        .wr_ch_i   (wrCh),
        .wr_duty_i (wrDuty),
        .wr_ready_o(wrReady),
        .mode_i    (mode),
        .pwm_o     (pwm),
        .period_o  (periodPulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to the next negedge at which period_o is high.
    task automatic waitPeriod();
        int n;
        n = 0;
        @(negedge clk);
        while (periodPulse !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) timedOut = 1'b1;
    endtask

    // From a period_o cycle, count clocks and per-channel highs up to the next one.
    task automatic measurePeriod();
        periodLen = 0;
        for (int c = 0; c < CH; c++) highCnt[c] = 0;
        do begin
            @(negedge clk);
            periodLen++;
            for (int c = 0; c < CH; c++) if (pwm[c] === 1'b1) highCnt[c]++;
        end while (periodPulse !== 1'b1 && periodLen < LIMIT);
        if (periodLen >= LIMIT) timedOut = 1'b1;
    endtask

    task automatic doWrite(input int ch, input int duty);
        int n;
        @(negedge clk);
        wrValid = 1'b1;
        wrCh    = 2'(ch);
        wrDuty  = 9'(duty);
        #1;
        n = 0;
        while (wrReady !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= LIMIT) timedOut = 1'b1;
        @(negedge clk);
        wrValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; psc = '0; wrValid = 1'b0; wrCh = '0; wrDuty = '0; mode = 1'b0;
        timedOut = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pwm !== 3'b000) begin errors++; $display("[TB] FAIL reset_pwm: got %b expected 000", pwm); end
        checks++;
        if (periodPulse !== 1'b0) begin errors++; $display("[TB] FAIL reset_period: got %b expected 0", periodPulse); end
        checks++;
        if (wrReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_ch0: got %b expected 1", wrReady); end
        wrCh = 2'd3;
        #1;
        checks++;
        if (wrReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready_ch3: got %b expected 1", wrReady); end
        wrCh = 2'd0;
    endtask

    task automatic test_basic();
        timedOut = 1'b0;
        doWrite(0, 64);
        @(negedge clk);
        en = 1'b1;
        waitPeriod();
        measurePeriod();
        checks++;
        if (periodLen !== 256) begin errors++; $display("[TB] FAIL basic_period_len: got %0d expected 256", periodLen); end
        checks++;
        if (highCnt[0] !== 64) begin errors++; $display("[TB] FAIL basic_ch0_high: got %0d expected 64", highCnt[0]); end
        checks++;
        if (highCnt[1] !== 0) begin errors++; $display("[TB] FAIL basic_ch1_idle: got %0d expected 0", highCnt[1]); end
        measurePeriod();
        checks++;
        if (highCnt[0] !== 64 || periodLen !== 256) begin
            errors++; $display("[TB] FAIL basic_second_period: got high=%0d len=%0d expected 64/256", highCnt[0], periodLen);
        end
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL basic_timeout: got 1 expected 0"); end
    endtask

    task automatic test_prescaler();
        timedOut = 1'b0;
        @(negedge clk);
        en  = 1'b0;
        psc = 32'd3;
        doWrite(1, 128);
        @(negedge clk);
        wrCh = 2'd1;
        #1;
        checks++;
        if (wrReady !== 1'b1) begin errors++; $display("[TB] FAIL disabled_commit_ready: got %b expected 1", wrReady); end
        checks++;
        if (pwm !== 3'b000) begin errors++; $display("[TB] FAIL disabled_pwm: got %b expected 000", pwm); end
        en = 1'b1;
        waitPeriod();
        measurePeriod();
        checks++;
        if (periodLen !== 1024) begin errors++; $display("[TB] FAIL psc_period_len: got %0d expected 1024", periodLen); end
        checks++;
        if (highCnt[1] !== 512) begin errors++; $display("[TB] FAIL psc_ch1_high: got %0d expected 512", highCnt[1]); end
        checks++;
        if (highCnt[0] !== 256) begin errors++; $display("[TB] FAIL psc_ch0_high: got %0d expected 256", highCnt[0]); end
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL psc_timeout: got 1 expected 0"); end
    endtask

    task automatic test_shadow();
        int high2;
        bit early;
        timedOut = 1'b0;
        @(negedge clk);
        en  = 1'b0;
        psc = '0;
        doWrite(2, 50);
        @(negedge clk);
        en = 1'b1;
        waitPeriod();
        high2 = 0;
        early = 1'b0;
        for (int k = 1; k <= 256; k++) begin
            @(negedge clk);
            if (pwm[2] === 1'b1) high2++;
            if (k < 256 && periodPulse === 1'b1) early = 1'b1;
            if (k == 10) begin
                wrValid = 1'b1; wrCh = 2'd2; wrDuty = 9'd200;
            end else if (k == 11) begin
                checks++;
                if (wrReady !== 1'b0) begin errors++; $display("[TB] FAIL shadow_ready_low: got %b expected 0", wrReady); end
                wrDuty = 9'd99;
            end else if (k == 12) begin
                checks++;
                if (wrReady !== 1'b0) begin errors++; $display("[TB] FAIL shadow_second_stalled: got %b expected 0", wrReady); end
                wrCh = 2'd0; wrDuty = 9'd32;
                #1;
                checks++;
                if (wrReady !== 1'b1) begin errors++; $display("[TB] FAIL shadow_other_ch_ready: got %b expected 1", wrReady); end
            end else if (k == 13) begin
                wrValid = 1'b0;
            end
        end
        checks++;
        if (periodPulse !== 1'b1 || early !== 1'b0) begin
            errors++; $display("[TB] FAIL shadow_boundary: got pulse=%b early=%b expected 1/0", periodPulse, early);
        end
        checks++;
        if (high2 !== 50) begin errors++; $display("[TB] FAIL shadow_old_duty_kept: got %0d expected 50", high2); end
        measurePeriod();
        checks++;
        if (highCnt[2] !== 200) begin errors++; $display("[TB] FAIL shadow_new_duty: got %0d expected 200", highCnt[2]); end
        checks++;
        if (highCnt[0] !== 32) begin errors++; $display("[TB] FAIL shadow_ch0_write: got %0d expected 32", highCnt[0]); end
        checks++;
        if (highCnt[1] !== 128 || periodLen !== 256) begin
            errors++; $display("[TB] FAIL shadow_ch1_untouched: got high=%0d len=%0d expected 128/256", highCnt[1], periodLen);
        end
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL shadow_timeout: got 1 expected 0"); end
    endtask

    task automatic test_clamp();
        timedOut = 1'b0;
        @(negedge clk);
        en = 1'b0;
        doWrite(0, 0);
        doWrite(1, 256);
        doWrite(2, 300);
        @(negedge clk);
        wrValid = 1'b1; wrCh = 2'd3; wrDuty = 9'd5;
        #1;
        checks++;
        if (wrReady !== 1'b1) begin errors++; $display("[TB] FAIL clamp_ch3_ready: got %b expected 1", wrReady); end
        @(negedge clk);
        wrValid = 1'b0;
        en = 1'b1;
        waitPeriod();
        measurePeriod();
        checks++;
        if (highCnt[0] !== 0) begin errors++; $display("[TB] FAIL clamp_duty0: got %0d expected 0", highCnt[0]); end
        checks++;
        if (highCnt[1] !== 256) begin errors++; $display("[TB] FAIL clamp_duty256: got %0d expected 256", highCnt[1]); end
        checks++;
        if (highCnt[2] !== 256) begin errors++; $display("[TB] FAIL clamp_duty300: got %0d expected 256", highCnt[2]); end
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL clamp_timeout: got 1 expected 0"); end
    endtask

`ifdef PWM_SERVO_EN
    task automatic test_mode();
        timedOut = 1'b0;
        @(negedge clk);
        en   = 1'b0;
        mode = 1'b1;
        doWrite(0, 0);
        doWrite(1, 256);
        doWrite(2, 128);
        @(negedge clk);
        en = 1'b1;
        waitPeriod();
        measurePeriod();
        checks++;
        if (highCnt[0] !== 12) begin errors++; $display("[TB] FAIL servo_duty0: got %0d expected 12", highCnt[0]); end
        checks++;
        if (highCnt[1] !== 24) begin errors++; $display("[TB] FAIL servo_duty256: got %0d expected 24", highCnt[1]); end
        checks++;
        if (highCnt[2] !== 18) begin errors++; $display("[TB] FAIL servo_duty128: got %0d expected 18", highCnt[2]); end
        repeat (50) @(negedge clk);
        mode = 1'b0;
        measurePeriod();
        measurePeriod();
        checks++;
        if (highCnt[0] !== 12 || highCnt[2] !== 18) begin
            errors++; $display("[TB] FAIL servo_flip_no_commit: got %0d/%0d expected 12/18", highCnt[0], highCnt[2]);
        end
        doWrite(2, 128);
        measurePeriod();
        measurePeriod();
        checks++;
        if (highCnt[2] !== 128) begin errors++; $display("[TB] FAIL servo_flip_after_commit: got %0d expected 128", highCnt[2]); end
        checks++;
        if (highCnt[0] !== 12) begin errors++; $display("[TB] FAIL servo_ch0_kept: got %0d expected 12", highCnt[0]); end
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL servo_timeout: got 1 expected 0"); end
    endtask
`else
    task automatic test_mode();
        timedOut = 1'b0;
        @(negedge clk);
        en   = 1'b0;
        mode = 1'b1;
        doWrite(0, 128);
        @(negedge clk);
        en = 1'b1;
        waitPeriod();
        measurePeriod();
        checks++;
        if (highCnt[0] !== 128) begin errors++; $display("[TB] FAIL mode_ignored: got %0d expected 128", highCnt[0]); end
        mode = 1'b0;
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL mode_timeout: got 1 expected 0"); end
    endtask
`endif

    task automatic test_reset_mid();
        timedOut = 1'b0;
        waitPeriod();
        repeat (100) @(negedge clk);
        wrValid = 1'b1; wrCh = 2'd1; wrDuty = 9'd77;
        @(negedge clk);
        wrValid = 1'b0;
        checks++;
        if (wrReady !== 1'b0) begin errors++; $display("[TB] FAIL midreset_pending: got %b expected 0", wrReady); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (pwm !== 3'b000) begin errors++; $display("[TB] FAIL midreset_pwm: got %b expected 000", pwm); end
        checks++;
        if (periodPulse !== 1'b0) begin errors++; $display("[TB] FAIL midreset_period: got %b expected 0", periodPulse); end
        checks++;
        if (wrReady !== 1'b1) begin errors++; $display("[TB] FAIL midreset_ready: got %b expected 1", wrReady); end
        rst = 1'b0;
        waitPeriod();
        measurePeriod();
        checks++;
        if (highCnt[0] !== 0 || highCnt[1] !== 0 || highCnt[2] !== 0) begin
            errors++; $display("[TB] FAIL midreset_thresholds: got %0d/%0d/%0d expected 0/0/0", highCnt[0], highCnt[1], highCnt[2]);
        end
        checks++;
        if (periodLen !== 256) begin errors++; $display("[TB] FAIL midreset_period_len: got %0d expected 256", periodLen); end
        checks++;
        if (timedOut !== 1'b0) begin errors++; $display("[TB] FAIL midreset_timeout: got 1 expected 0"); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_basic();
        test_prescaler();
        test_shadow();
        test_clamp();
        test_mode();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pwm_multich.md
# pwm_multich

Parametrised multi-channel PWM generator: the next generation of the team's single-prescaler, three-output PWM.
- Shared programmable prescaler and period counter; CH independent channels with RES-bit resolution.
- Each channel's duty is written over a valid/ready port, held in a shadow register and committed only at the period boundary, so duty changes are glitch-free.
- Optional servo mode maps duty onto a 5 %–10 % pulse window.
- Sits between the register/control front-end and the output pads.

## Interface
- CH, 3, number of PWM channels (1..16)
- RES, 8, period counter width; period = 2^RES ticks (RES ≥ 5)
- PSC_W, 32, prescaler width
- clk  in  1  system clock, all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- en_i  in  1  run enable
- psc_i  in  PSC_W  prescaler divide value; tick every psc_i+1 clocks
- wr_valid_i  in  1  duty write request
- wr_ch_i  in  $clog2(CH) (min 1)  target channel
- wr_duty_i  in  RES+1  requested duty in ticks
- wr_ready_o  out  1  write can be accepted
- mode_i  in  1  0 = normal, 1 = servo (used only with PWM_SERVO_EN)
- pwm_o  out  CH  registered PWM outputs
- period_o  out  1  one-clock pulse at each period start

## Operation
- Prescaler q (PSC_W bits):
  - tick = en_i && q == psc_i, then q ← 0; otherwise q ← q+1.
  - psc_i = 0 gives a tick every clock.
  - If psc_i is lowered below the current q, q counts up, wraps at 2^PSC_W, then ticks normally; no special handling.
- Period counter cnt (RES bits): increments on tick and wraps 2^RES−1 → 0. wrap = tick && cnt == 2^RES−1.
- Duty clamp: values > 2^RES are clamped to 2^RES.
- Shadow registers: per channel pend_duty[RES+1], pend_flag, act_thr[RES+1].
- wr_ready_o = !pend_flag[wr_ch_i] (combinational from registered state).
- Write accepted when wr_valid_i && wr_ready_o:
  - pend_duty ← clamped duty, pend_flag ← 1.
  - wr_ch_i ≥ CH: accepted and dropped; wr_ready_o = 1 for it.
- Commit on wrap, or on every clock while en_i = 0:
  - each channel with pend_flag set loads act_thr from its computed threshold and clears pend_flag;
  - mode_i is sampled at the same moment.
- Thresholds:
  - Normal: thr = duty. 0 = constantly low; 2^RES = constantly high.
  - Servo: thr = SB + ((duty × SB) >> RES), with SB = 2^RES / 20 (integer floor). The multiply is performed at RES+1+RES width, no overflow.
- Output: pwm_o[c] ← en_i && ({1'b0,cnt} < act_thr[c]).
- en_i = 0: q and cnt held at 0, pwm_o driven 0, period_o 0. Writes are still accepted and committed immediately.
- Simultaneous write and commit on the same channel cannot occur, because ready is low while pend_flag is set. The write is accepted the cycle after the commit.

## Timing
- Reset values: q = 0, cnt = 0, pend_flag = 0, act_thr = 0, pwm_o = 0, period_o = 0, wr_ready_o = 1, latched mode = normal.
- pwm_o lags the cnt value by one clock (registered compare).
- period_o is high for exactly the one clock following the wrap tick, the same cycle cnt = 0 first appears.
- Write-to-output latency: the new duty is visible in the first period after the next period_o pulse. With en_i = 0, act_thr updates 1 cycle after acceptance.
- Reset asserted mid-period: on the next edge all state returns to its reset values and pending writes are lost.

## Configuration
- PWM_SERVO_EN defined: servo mapping logic and the latched mode bit are present, and mode_i selects the threshold function.
- PWM_SERVO_EN undefined: mode_i is ignored and unconnected internally. Only the normal threshold exists, and no multiplier is synthesised.

## Structure
- Shared package pwm_pkg: MODE_NORMAL = 1'b0, MODE_SERVO = 1'b1, SERVO_DIV = 20.
- Sub-module pwm_timebase holds the prescaler, period counter, tick/wrap and period_o generation (params PSC_W, RES; ports clk, rst_i, en_i, psc_i, tick, wrap, cnt, period_o).
- Channel shadow, commit and compare logic live in the top module as a generate loop over CH.

## Test plan
- CH=3, RES=8, psc_i=0, write ch0 duty 64, en_i=1 -> pwm_o[0] high 64 of every 256 clocks; period_o every 256 clocks.
- psc_i=3, ch1 duty 128 -> period 1024 clocks, pwm_o[1] high for 512.
- Mid-period write ch2 duty 200 after duty 50:
  - -> pwm_o[2] keeps 50 until period_o, then 200;
  - wr_ready_o low for ch2 until commit;
  - a second ch2 write is stalled, and a ch0 write in the same cycle is accepted.
- Duty 0 -> pwm_o constantly 0; duty 256 and 300 -> constantly 1 (clamp); wr_ch_i = 3 -> accepted, no channel changes.
- PWM_SERVO_EN, mode_i=1:
  - duty 0 -> 12-tick pulse; duty 256 -> 24 ticks; duty 128 -> 18 ticks;
  - mode flip mid-period takes effect only after the next commit.
- Reset at cnt=100 with pending writes -> next cycle pwm_o = 0, period_o = 0, wr_ready_o = 1, all thresholds 0.
